// File: rtl/aes128_pkg.sv
// Shared AES-128 key-schedule primitives: S-box, round constants and word helpers.
// Words are held with byte 0 in bits [31:24], matching the big-endian key layout.
package aes128_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] Sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] Rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] RotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] SubWord(input logic [31:0] w);
    return {Sbox(w[31:24]), Sbox(w[23:16]), Sbox(w[15:8]), Sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One combinational key-schedule step, forward (dir=0) or inverse (dir=1).
// A single SubWord is shared: forward feeds w3, inverse feeds the recovered w3^w2.
module aes128_key_step
  import aes128_pkg::*;
(
  input  logic [0:127] kr,
  input  logic [3:0]   rnd,
  input  logic         dir,
  output logic [0:127] next_kr
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv1, inv2, inv3;
  logic [31:0] fwd1, fwd2, fwd3;
  logic [31:0] subIn, mixWord, new0;
  logic [7:0]  rc;

  always_comb begin
    w0 = kr[0:31];
    w1 = kr[32:63];
    w2 = kr[64:95];
    w3 = kr[96:127];

    inv1 = w1 ^ w0;
    inv2 = w2 ^ w1;
    inv3 = w3 ^ w2;

    // Forward builds round rnd+1; inverse undoes round rnd, so it uses Rcon[rnd].
    subIn   = dir ? inv3 : w3;
    rc      = Rcon(dir ? rnd : rnd + 4'd1);
    mixWord = SubWord(RotWord(subIn)) ^ {rc, 24'h000000};
    new0    = w0 ^ mixWord;

    fwd1 = w1 ^ new0;
    fwd2 = w2 ^ fwd1;
    fwd3 = w3 ^ fwd2;

    next_kr = dir ? {new0, inv1, inv2, inv3} : {new0, fwd1, fwd2, fwd3};
  end

endmodule

// File: rtl/aes128_inv_key_sched.sv
// Iterative AES-128 round-key sequencer with a single working register.
// REVERSE=1 expands to round 10 first and then walks back with the inverse step.
module aes128_inv_key_sched
  import aes128_pkg::*;
#(
  parameter bit REVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk,
  output logic [3:0]   rk_index,
  output logic         rk_last
);

  localparam logic [3:0] LAST_RND = REVERSE ? 4'd0 : 4'd10;

  state_t       st_q, st_d;
  logic [0:127] kr_q, kr_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] stepKr;
  logic         stepDir;

  assign stepDir = REVERSE && (st_q == EMIT);

  aes128_key_step u_step (
    .kr      (kr_q),
    .rnd     (rnd_q),
    .dir     (stepDir),
    .next_kr (stepKr)
  );

  always_comb begin
    st_d  = st_q;
    kr_d  = kr_q;
    rnd_d = rnd_q;
    case (st_q)
      IDLE: begin
        if (key_valid) begin
          kr_d  = key;
          rnd_d = 4'd0;
          st_d  = REVERSE ? EXPAND : EMIT;
        end
      end
      EXPAND: begin
        kr_d  = stepKr;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd9) st_d = EMIT;
      end
      EMIT: begin
        if (rk_ready) begin
          if (rnd_q == LAST_RND) begin
            st_d = IDLE;
          end else begin
            kr_d  = stepKr;
            rnd_d = REVERSE ? rnd_q - 4'd1 : rnd_q + 4'd1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      kr_q  <= '0;
      rnd_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      kr_q  <= kr_d;
      rnd_q <= rnd_d;
    end
  end

  // Every output decodes registered state only, so nothing flows through from inputs.
  assign key_ready = (st_q == IDLE);
  assign rk_valid  = (st_q == EMIT);
  assign rk        = kr_q;
  assign rk_index  = rnd_q;
  assign rk_last   = (st_q == EMIT) && (rnd_q == LAST_RND);

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Directed bench for the AES-128 round-key sequencer in both emit orders.
// Expected round keys are the published AES-128 schedule for 2b7e1516...4f3c.
module tb_aes128_inv_key_sched;

  typedef struct {
    logic [127:0] cipherKey;
    int           idx;
    logic [127:0] expRk;
  } vec_t;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         resetN;
  logic [0:127] key;
  logic         revKeyValid, fwdKeyValid;
  logic         rkReady;
  logic         revKeyReady, fwdKeyReady;
  logic         revRkValid, fwdRkValid;
  logic [0:127] revRk, fwdRk;
  logic [3:0]   revRkIndex, fwdRkIndex;
  logic         revRkLast, fwdRkLast;

  bit   useFwd;
  int   assertCount;
  int   failCount;
  vec_t vecs[11];

  wire          curKeyReady = useFwd ? fwdKeyReady : revKeyReady;
  wire          curRkValid  = useFwd ? fwdRkValid  : revRkValid;
  wire [127:0]  curRk       = useFwd ? fwdRk       : revRk;
  wire [3:0]    curRkIndex  = useFwd ? fwdRkIndex  : revRkIndex;
  wire          curRkLast   = useFwd ? fwdRkLast   : revRkLast;

  aes128_inv_key_sched #(.REVERSE(1'b1)) dutRev (
    .clk       (clk),
    .reset     (resetN),
    .key_valid (revKeyValid),
    .key_ready (revKeyReady),
    .key       (key),
    .rk_valid  (revRkValid),
    .rk_ready  (rkReady),
    .rk        (revRk),
    .rk_index  (revRkIndex),
    .rk_last   (revRkLast)
  );

  aes128_inv_key_sched #(.REVERSE(1'b0)) dutFwd (
    .clk       (clk),
    .reset     (resetN),
    .key_valid (fwdKeyValid),
    .key_ready (fwdKeyReady),
    .key       (key),
    .rk_valid  (fwdRkValid),
    .rk_ready  (rkReady),
    .rk        (fwdRk),
    .rk_index  (fwdRkIndex),
    .rk_last   (fwdRkLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents a key for exactly one edge and returns at the sample point after it.
  task automatic applyStimulus(input logic [127:0] k, input bit fwd);
    checkOutput("keyReady before accept", {127'b0, curKeyReady}, 128'd1);
    key = k;
    if (fwd) fwdKeyValid = 1'b1;
    else     revKeyValid = 1'b1;
    @(posedge clk); #1;
    revKeyValid = 1'b0;
    fwdKeyValid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!curRkValid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Receives all 11 round keys in order, optionally stalling on index 7 then randomizing ready.
  task automatic collectKeys(input bit fwd, input bit doStall, input string tag);
    int  n = 0;
    int  cycles = 0;
    int  stallLeft = 5;
    int  readyHigh = 0;
    int  expIdx;
    bit  stallDone = 1'b0;
    while (n < 11 && cycles < 200) begin
      if (curKeyReady) readyHigh++;
      if (curRkValid) begin
        expIdx = fwd ? n : 10 - n;
        if (doStall && expIdx == 7 && stallLeft > 0) begin
          rkReady = 1'b0;
          stallLeft--;
          checkOutput({tag, " stall index"}, {124'b0, curRkIndex}, 128'd7);
          checkOutput({tag, " stall rk"}, curRk, vecs[7].expRk);
          if (stallLeft == 0) stallDone = 1'b1;
        end else begin
          rkReady = (doStall && stallDone) ? 1'($urandom_range(0, 1)) : 1'b1;
          if (rkReady) begin
            checkOutput({tag, " index"}, {124'b0, curRkIndex}, 128'(expIdx));
            checkOutput({tag, " rk"}, curRk, vecs[expIdx].expRk);
            checkOutput({tag, " last"}, {127'b0, curRkLast}, {127'b0, n == 10});
            n++;
          end
        end
      end else begin
        rkReady = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    rkReady = 1'b1;
    checkOutput({tag, " keys delivered"}, 128'(n), 128'd11);
    checkOutput({tag, " keyReady while busy"}, 128'(readyHigh), 128'd0);
    if (!doStall) checkOutput({tag, " burst cycles"}, 128'(cycles), 128'd11);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " keyReady"}, {127'b0, curKeyReady}, 128'd1);
    checkOutput({tag, " rkValid"},  {127'b0, curRkValid},  128'd0);
    checkOutput({tag, " rk"},       curRk,                 128'd0);
    checkOutput({tag, " rkIndex"},  {124'b0, curRkIndex},  128'd0);
    checkOutput({tag, " rkLast"},   {127'b0, curRkLast},   128'd0);
  endtask

  initial begin
    int waitN;
    int spurious;
    logic [127:0] rkTable [11];

    rkTable[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rkTable[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rkTable[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rkTable[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rkTable[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rkTable[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rkTable[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rkTable[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rkTable[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rkTable[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rkTable[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) vecs[i] = '{cipherKey: KEY_A, idx: i, expRk: rkTable[i]};

    assertCount = 0;
    failCount   = 0;
    useFwd      = 1'b0;
    resetN      = 1'b0;
    key         = '0;
    revKeyValid = 1'b0;
    fwdKeyValid = 1'b0;
    rkReady     = 1'b1;

    #3;
    useFwd = 1'b0; checkResetState("rev reset");
    useFwd = 1'b1; checkResetState("fwd reset");
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reverse order, ready held high");
    useFwd = 1'b0;
    applyStimulus(vecs[0].cipherKey, 1'b0);
    checkOutput("rev keyReady after accept", {127'b0, curKeyReady}, 128'd0);
    waitValid(waitN);
    checkOutput("rev first latency", 128'(waitN), 128'd10);
    collectKeys(1'b0, 1'b0, "rev");
    checkOutput("rev keyReady after last", {127'b0, curKeyReady}, 128'd1);
    checkOutput("rev rkValid after last", {127'b0, curRkValid}, 128'd0);

    $display("[TB] forward order, ready held high");
    useFwd = 1'b1;
    applyStimulus(vecs[0].cipherKey, 1'b1);
    waitValid(waitN);
    checkOutput("fwd first latency", 128'(waitN), 128'd0);
    collectKeys(1'b1, 1'b0, "fwd");
    checkOutput("fwd keyReady after last", {127'b0, curKeyReady}, 128'd1);

    $display("[TB] reverse order with backpressure");
    useFwd = 1'b0;
    applyStimulus(vecs[0].cipherKey, 1'b0);
    waitValid(waitN);
    collectKeys(1'b0, 1'b1, "bp");
    checkOutput("bp keyReady after last", {127'b0, curKeyReady}, 128'd1);

    $display("[TB] reset during expansion");
    applyStimulus(vecs[0].cipherKey, 1'b0);
    waitN = 0;
    while (curRkIndex != 4'd5 && waitN < 20) begin
      @(posedge clk); #1;
      waitN++;
    end
    checkOutput("reached round 5", 128'(waitN), 128'd5);
    resetN = 1'b0;
    #1;
    checkResetState("mid reset");
    @(posedge clk); #1;
    resetN = 1'b1;
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (curRkValid) spurious++;
    end
    checkOutput("no output after release", 128'(spurious), 128'd0);
    applyStimulus(KEY_ZERO, 1'b0);
    waitValid(waitN);
    checkOutput("zero key latency", 128'(waitN), 128'd10);
    checkOutput("zero key index", {124'b0, curRkIndex}, 128'd10);
    checkOutput("zero key rk10", curRk, ZERO_RK10);
    waitN = 0;
    while (!curKeyReady && waitN < 40) begin
      @(posedge clk); #1;
      waitN++;
    end
    checkOutput("zero key drained", {127'b0, curKeyReady}, 128'd1);

    $display("[TB] second key held valid while busy");
    key = KEY_A;
    revKeyValid = 1'b1;
    @(posedge clk); #1;
    key = KEY_ZERO;
    waitValid(waitN);
    checkOutput("busy first latency", 128'(waitN), 128'd10);
    collectKeys(1'b0, 1'b0, "busy");
    checkOutput("busy keyReady in gap", {127'b0, curKeyReady}, 128'd1);
    @(posedge clk); #1;
    revKeyValid = 1'b0;
    checkOutput("busy second accepted", {127'b0, curKeyReady}, 128'd0);
    waitValid(waitN);
    checkOutput("busy second latency", 128'(waitN), 128'd10);
    checkOutput("busy second rk10", curRk, ZERO_RK10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
